// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shift register with a
// valid/ready load handshake and a shift enable that can stall the output.
//
// Parameters
//   WIDTH      : parallel word width, 2..64
//   MSB_FIRST  : 1 = din[WIDTH-1] leaves first, 0 = din[0] leaves first
//   IDLE_LEVEL : q_out level while idle; also the bit shifted in as fill
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   load_valid : a word is offered on din
//   load_ready : din is accepted this cycle (combinational)
//   din        : parallel word
//   shift_en   : advance one bit this cycle; 0 stalls the word in place
//   q_out      : serial data
//   q_valid    : q_out carries a data bit
//   busy       : a word is being shifted
//   done       : last bit of the word is consumed this cycle (combinational)
//   bit_cnt    : index of the bit currently on q_out (0 = first bit)
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         din,
  input  logic                     shift_en,
  output logic                     q_out,
  output logic                     q_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     FILL     = {WIDTH{IDLE_LEVEL}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  // Register image after one shift toward the output end
  logic [WIDTH-1:0] shreg_shifted;
  logic             last_bit;

  // State, shift register and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= FILL;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Shift direction follows the output end selected by MSB_FIRST
  always_comb begin
    shreg_shifted = shreg_q;
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[WIDTH-2:0], IDLE_LEVEL};
    end else begin
      shreg_shifted = {IDLE_LEVEL, shreg_q[WIDTH-1:1]};
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    load_ready = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    q_valid    = 1'b0;
    q_out      = IDLE_LEVEL;
    last_bit   = (bit_cnt_q == LAST_IDX);

    case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy    = 1'b1;
        q_valid = 1'b1;
        q_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        if (shift_en) begin
          if (last_bit) begin
            // Last bit consumed: reload without a gap, or drop back to idle
            done       = 1'b1;
            load_ready = 1'b1;
            bit_cnt_d  = '0;
            if (load_valid) begin
              shreg_d = din;
            end else begin
              shreg_d = FILL;
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d   = shreg_shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        shreg_d   = FILL;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign bit_cnt = bit_cnt_q;

endmodule
